instr_sequencer: RTL

- Hardwired control unit that sequences the existing Datapath through fetch (T0-T2) and execute (T3-T6), one state per clock.
- Replaces the hand-driven strobe timing now written into benches; drives every datapath control input.
- Sits beside Datapath and reads its IR contents. Supports 3-register ALU ops, mul/div into HI/LO, mfhi/mflo, nop and halt, with a memory wait handshake and a retired-instruction counter.

---
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - hardwired fetch/execute control unit for the Datapath
module instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Mem_Wait,
    input  logic [31:0]      IR_Q,
    output logic             PC_Out,
    output logic             MAR_In,
    output logic             IncPC,
    output logic             Z_In,
    output logic             ZLO_Out,
    output logic             ZHI_Out,
    output logic             PC_In,
    output logic             Read,
    output logic             MDR_In,
    output logic             MDR_Out,
    output logic             IR_In,
    output logic             Y_In,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             R_In,
    output logic             R_Out,
    output logic             HI_In,
    output logic             LO_In,
    output logic             HI_Out,
    output logic             LO_Out,
    output logic [4:0]       CONTROL,
    output logic             Run,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instr_Count
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    logic [4:0] opcode;
    logic       is_alu, is_muldiv, is_mfhi, is_mflo, is_nop, is_halt;
    logic [4:0] alu_ctrl;

    assign opcode = IR_Q[31:27];

    always_comb begin
        is_alu    = 1'b0;
        is_muldiv = 1'b0;
        is_mfhi   = 1'b0;
        is_mflo   = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        alu_ctrl  = 5'b00000;
        case (opcode)
            5'b00000: begin is_alu = 1'b1;    alu_ctrl = 5'b00000; end
            5'b00001: begin is_alu = 1'b1;    alu_ctrl = 5'b00001; end
            5'b00010: begin is_alu = 1'b1;    alu_ctrl = 5'b00100; end
            5'b00011: begin is_alu = 1'b1;    alu_ctrl = 5'b00101; end
            5'b01001: begin is_muldiv = 1'b1; alu_ctrl = 5'b00010; end
            5'b01010: begin is_muldiv = 1'b1; alu_ctrl = 5'b00011; end
            5'b10000: is_mfhi = 1'b1;
            5'b10001: is_mflo = 1'b1;
            5'b11000: is_nop  = 1'b1;
            5'b11001: is_halt = 1'b1;
            default:  ;
        endcase
    end

    // Outputs are pure Moore decode of state (plus IR in execute), so an async
    // Clear that forces IDLE drops every strobe within the same cycle.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        PC_Out  = 1'b0; MAR_In  = 1'b0; IncPC   = 1'b0; Z_In    = 1'b0;
        ZLO_Out = 1'b0; ZHI_Out = 1'b0; PC_In   = 1'b0; Read    = 1'b0;
        MDR_In  = 1'b0; MDR_Out = 1'b0; IR_In   = 1'b0; Y_In    = 1'b0;
        Gra     = 1'b0; Grb     = 1'b0; Grc     = 1'b0; R_In    = 1'b0;
        R_Out   = 1'b0; HI_In   = 1'b0; LO_In   = 1'b0; HI_Out  = 1'b0;
        LO_Out  = 1'b0; CONTROL = 5'b00000; Run = 1'b0; Illegal = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) state_d = S_T0;
            end
            S_T0: begin
                Run = 1'b1; PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; Z_In = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Run = 1'b1; ZLO_Out = 1'b1; PC_In = 1'b1; Read = 1'b1; MDR_In = 1'b1;
                if (!Mem_Wait) state_d = S_T2;
            end
            S_T2: begin
                Run = 1'b1; MDR_Out = 1'b1; IR_In = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_alu || is_muldiv) begin
                    Grb = 1'b1; R_Out = 1'b1; Y_In = 1'b1;
                    state_d = S_T4;
                end else if (is_mfhi || is_mflo) begin
                    HI_Out = is_mfhi; LO_Out = is_mflo; Gra = 1'b1; R_In = 1'b1;
                    retire = 1'b1; state_d = S_T0;
                end else if (is_nop) begin
                    retire = 1'b1; state_d = S_T0;
                end else if (is_halt) begin
                    retire = 1'b1; state_d = S_HALT;
                end else begin
                    Illegal = 1'b1; state_d = S_T0;
                end
            end
            S_T4: begin
                Run = 1'b1; Grc = 1'b1; R_Out = 1'b1; Z_In = 1'b1; CONTROL = alu_ctrl;
                state_d = S_T5;
            end
            S_T5: begin
                Run = 1'b1; ZLO_Out = 1'b1;
                if (is_muldiv) begin
                    LO_In = 1'b1; state_d = S_T6;
                end else begin
                    Gra = 1'b1; R_In = 1'b1; retire = 1'b1; state_d = S_T0;
                end
            end
            S_T6: begin
                Run = 1'b1; ZHI_Out = 1'b1; HI_In = 1'b1;
                retire = 1'b1; state_d = S_T0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    assign Instr_Count = count_q;

endmodule
